f_demux_lane: RTL and testbench

// - Sequential inverse of the PP3 F-mux: accepts one time-multiplexed word stream

---
 rtl/f_demux_lane.sv | 125 ++++++++++++
 tb/tb_f_demux_lane.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/f_demux_lane.sv
// Two-lane receive splitter: one valid/ready word stream steered by in_sel into two FWFT FIFOs.
// Optional sticky lane-alternation checker enabled by defining F_DEMUX_ALT_CHECK_EN.
module f_demux_lane #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 2
) (
  input  logic             QCK,
  input  logic             QRT_N,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             alt_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("f_demux_lane: DEPTH must be a power of two and at least 2");
  end

  // Assert asynchronously, release two QCK edges after QRT_N rises.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge QCK or negedge QRT_N) begin
    if (!QRT_N) rst_sync_q <= '0;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n = rst_sync_q[1];

  logic [1:0][CW-1:0] cnt_q, cnt_d;
  logic [1:0][AW-1:0] wr_q, wr_d;
  logic [1:0][AW-1:0] rd_q, rd_d;
  logic [WIDTH-1:0]   mem_q [2][DEPTH];
  logic [1:0]         full, empty, push, pop;
  logic               push_any;

  assign full[0]  = (cnt_q[0] == CW'(DEPTH));
  assign full[1]  = (cnt_q[1] == CW'(DEPTH));
  assign empty[0] = (cnt_q[0] == '0);
  assign empty[1] = (cnt_q[1] == '0);

  // Ready looks only at the selected lane's registered count.
  assign in_ready = ~full[in_sel];
  assign push_any = in_valid & in_ready;
  assign push     = {push_any & in_sel, push_any & ~in_sel};
  assign pop      = {out1_ready & ~empty[1], out0_ready & ~empty[0]};

  always_comb begin
    cnt_d = cnt_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    for (int unsigned n = 0; n < 2; n++) begin
      if (push[n]) wr_d[n] = wr_q[n] + 1'b1;
      if (pop[n])  rd_d[n] = rd_q[n] + 1'b1;
      if (push[n] && !pop[n])      cnt_d[n] = cnt_q[n] + 1'b1;
      else if (!push[n] && pop[n]) cnt_d[n] = cnt_q[n] - 1'b1;
    end
  end

  always_ff @(posedge QCK or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
    end
  end

  // Storage needs no reset: reads are gated by the empty flag.
  always_ff @(posedge QCK) begin
    if (push_any) mem_q[in_sel][wr_q[in_sel]] <= in_data;
  end

  assign out0_valid = ~empty[0];
  assign out1_valid = ~empty[1];
  assign out0_data  = empty[0] ? '0 : mem_q[0][rd_q[0]];
  assign out1_data  = empty[1] ? '0 : mem_q[1][rd_q[1]];

`ifdef F_DEMUX_ALT_CHECK_EN
  logic last_sel_q, last_sel_d;
  logic first_seen_q, first_seen_d;
  logic alt_err_q, alt_err_d;

  always_comb begin
    last_sel_d   = last_sel_q;
    first_seen_d = first_seen_q;
    alt_err_d    = alt_err_q;
    if (push_any) begin
      last_sel_d   = in_sel;
      first_seen_d = 1'b1;
      if (first_seen_q && (in_sel == last_sel_q)) alt_err_d = 1'b1;
    end
  end

  always_ff @(posedge QCK or negedge rst_n) begin
    if (!rst_n) begin
      last_sel_q   <= 1'b0;
      first_seen_q <= 1'b0;
      alt_err_q    <= 1'b0;
    end else begin
      last_sel_q   <= last_sel_d;
      first_seen_q <= first_seen_d;
      alt_err_q    <= alt_err_d;
    end
  end

  assign alt_err = alt_err_q;
`else
  assign alt_err = 1'b0;
`endif

endmodule

// File: tb/tb_f_demux_lane.sv
// Directed bench for f_demux_lane: DUT a (WIDTH=8, DEPTH=2) and DUT b (WIDTH=8, DEPTH=4).
// Expected alt_err follows F_DEMUX_ALT_CHECK_EN.
module tb_f_demux_lane;

`ifdef F_DEMUX_ALT_CHECK_EN
  localparam logic ALT = 1'b1;
`else
  localparam logic ALT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  int         checks = 0;
  int         errors = 0;

  logic       a_iv, a_sel, a_r0, a_r1, a_ir, a_v0, a_v1, a_err;
  logic [7:0] a_d, a_d0, a_d1;
  logic       b_iv, b_sel, b_r0, b_r1, b_ir, b_v0, b_v1, b_err;
  logic [7:0] b_d, b_d0, b_d1;

  always #5 clk = ~clk;

  f_demux_lane #(.WIDTH(8), .DEPTH(2)) u_a (
    .QCK(clk), .QRT_N(rst_n),
    .in_valid(a_iv), .in_ready(a_ir), .in_sel(a_sel), .in_data(a_d),
    .out0_valid(a_v0), .out0_ready(a_r0), .out0_data(a_d0),
    .out1_valid(a_v1), .out1_ready(a_r1), .out1_data(a_d1),
    .alt_err(a_err)
  );

  f_demux_lane #(.WIDTH(8), .DEPTH(4)) u_b (
    .QCK(clk), .QRT_N(rst_n),
    .in_valid(b_iv), .in_ready(b_ir), .in_sel(b_sel), .in_data(b_d),
    .out0_valid(b_v0), .out0_ready(b_r0), .out0_data(b_d0),
    .out1_valid(b_v1), .out1_ready(b_r1), .out1_data(b_d1),
    .alt_err(b_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int sent;
    int recv;
    rst_n = 1'b0;
    a_iv = 0; a_sel = 0; a_d = '0; a_r0 = 0; a_r1 = 0;
    b_iv = 0; b_sel = 0; b_d = '0; b_r0 = 0; b_r1 = 0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();

    check("rst_v0", a_v0, 1'b0);
    check("rst_d0", a_d0, 8'h00);
    check("rst_v1", a_v1, 1'b0);
    check("rst_ir", a_ir, 1'b1);
    check("rst_err", a_err, 1'b0);
    check("rst_b_v1", b_v1, 1'b0);

    // Alternate: A5 to lane 0, then 3C to lane 1, consumers always ready
    a_r0 = 1; a_r1 = 1;
    a_iv = 1; a_sel = 0; a_d = 8'hA5;
    tick();
    check("alt_v0_k1", a_v0, 1'b1);
    check("alt_d0_k1", a_d0, 8'hA5);
    check("alt_v1_k1", a_v1, 1'b0);
    a_sel = 1; a_d = 8'h3C;
    tick();
    a_iv = 0;
    check("alt_v0_k2", a_v0, 1'b0);
    check("alt_d0_k2", a_d0, 8'h00);
    check("alt_v1_k2", a_v1, 1'b1);
    check("alt_d1_k2", a_d1, 8'h3C);
    tick();
    check("alt_v1_k3", a_v1, 1'b0);
    check("alt_d1_k3", a_d1, 8'h00);
    check("alt_err_ok", a_err, 1'b0);

    // Full: lane 0 holds two words, third refused until a pop
    a_r0 = 0; a_iv = 1; a_sel = 0; a_d = 8'h11;
    #1 check("full_ir_11", a_ir, 1'b1);
    tick();
    a_d = 8'h22;
    #1 check("full_ir_22", a_ir, 1'b1);
    tick();
    a_d = 8'h33;
    #1 check("full_ir_33", a_ir, 1'b0);
    check("full_v0", a_v0, 1'b1);
    check("full_d0_11", a_d0, 8'h11);
    tick();
    check("full_hold_11", a_d0, 8'h11);
    a_r0 = 1;
    #1 check("full_no_ready_thru", a_ir, 1'b0);
    tick();
    check("full_d0_22", a_d0, 8'h22);
    check("full_ir_after_pop", a_ir, 1'b1);
    tick();
    a_iv = 0;
    check("full_d0_33", a_d0, 8'h33);
    check("full_v0_33", a_v0, 1'b1);
    tick();
    check("full_drained", a_v0, 1'b0);
    check("full_err", a_err, ALT);

    // Full+pop on lane 1: push refused, pop proceeds
    a_r1 = 0; a_iv = 1; a_sel = 1; a_d = 8'h44;
    tick();
    a_d = 8'h55;
    tick();
    a_d = 8'h66; a_r1 = 1;
    #1 check("fp_ir_full", a_ir, 1'b0);
    check("fp_v1", a_v1, 1'b1);
    check("fp_d1_44", a_d1, 8'h44);
    tick();
    check("fp_d1_55", a_d1, 8'h55);
    check("fp_ir_free", a_ir, 1'b1);
    a_iv = 0;
    tick();
    check("fp_empty", a_v1, 1'b0);

    // Reset mid-burst with two words buffered in lane 0
    a_r0 = 0; a_iv = 1; a_sel = 0; a_d = 8'h77;
    tick();
    a_d = 8'h88;
    tick();
    a_d = 8'h99;
    #1 check("mrst_pre_d0", a_d0, 8'h77);
    #2 rst_n = 1'b0;
    #1 check("mrst_v0_async", a_v0, 1'b0);
    check("mrst_d0_async", a_d0, 8'h00);
    check("mrst_ir_async", a_ir, 1'b1);
    check("mrst_err", a_err, 1'b0);
    tick();
    check("mrst_v0_next", a_v0, 1'b0);
    check("mrst_d0_next", a_d0, 8'h00);
    check("mrst_ir_next", a_ir, 1'b1);
    a_iv = 0;
    rst_n = 1'b1;
    repeat (3) tick();
    check("mrst_v0_after", a_v0, 1'b0);

    // Alternation checker: accepted sels 0,1,1
    a_r0 = 1; a_r1 = 1; a_iv = 1; a_sel = 0; a_d = 8'h01;
    tick();
    check("altchk_1", a_err, 1'b0);
    a_sel = 1; a_d = 8'h02;
    tick();
    check("altchk_2", a_err, 1'b0);
    a_d = 8'h03;
    tick();
    a_iv = 0;
    check("altchk_3", a_err, ALT);
    check("altchk_stored", a_d1, 8'h03);
    tick();
    check("altchk_sticky", a_err, ALT);

    // Wrap on DEPTH=4: stream 0..15 into lane 1, consumer ready toggling
    sent = 0;
    recv = 0;
    b_sel = 1;
    for (int cyc = 0; cyc < 200 && recv < 16; cyc++) begin
      b_iv = (sent < 16);
      b_d  = 8'(sent);
      b_r1 = ~b_r1;
      #1;
      if (b_v1 && b_r1) begin
        check("wrap_data", b_d1, 32'(recv));
        recv++;
      end
      if (b_iv && b_ir) sent++;
      tick();
    end
    b_iv = 0; b_r1 = 0;
    check("wrap_count", recv, 16);
    #1 check("wrap_no_dup", b_v1, 1'b0);
    check("wrap_lane0_idle", b_v0, 1'b0);
    check("wrap_err", b_err, ALT);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
